branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, giving the number of branch-history entries; power of 2, minimum 2.
REQ-003 SHALL have parameter CNT_W, default 16, giving the mispredict counter width.
REQ-004 clk  input  1  sole clock; all state rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pred_pc  input  32  fetch-stage PC used for prediction lookup.
REQ-007 pred_taken  output  1  combinational prediction for pred_pc.
REQ-008 res_valid  input  1  a branch is presented for resolution this cycle.
REQ-009 res_pc  input  32  PC of the branch being resolved.
REQ-010 rd1  input  WIDTH  first register operand.
REQ-011 rd2  input  WIDTH  second register operand.
REQ-012 BTypeOp  input  3  branch condition select.
REQ-013 res_pred  input  1  prediction originally issued for this branch.
REQ-014 flush  input  1  squashes the resolution presented this cycle.
REQ-015 res_done  output  1  registered; resolution result valid.
REQ-016 BResult  output  1  registered; 1 = branch condition true (taken).
REQ-017 mispredict  output  1  registered; BResult differs from res_pred.
REQ-018 illegal_op  output  1  registered; BTypeOp code unsupported.
REQ-019 mispredict_cnt  output  CNT_W  saturating count of mispredicts.

Function
REQ-020 BTypeOp encodings SHALL be: 000 BEQ (rd1==rd2), 001 BNE (rd1!=rd2), 010 BLEZ (rd1<=0), 011 BGTZ (rd1>0), 100 BLTZ (rd1<0), 101 BGEZ (rd1>=0); 110 and 111 are illegal.
REQ-021 All comparisons against zero SHALL treat rd1 as signed two's complement of WIDTH bits; rd2 is ignored for codes 010-101.
REQ-022 Illegal codes SHALL evaluate to not taken and set illegal_op for that resolution; they SHALL NOT update the BHT or mispredict_cnt.
REQ-023 The BHT SHALL hold BHT_DEPTH 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2].
REQ-024 pred_taken SHALL equal bit 1 of the counter indexed by pred_pc, with no registering.
REQ-025 A resolution is accepted when res_valid=1 and flush=0 at a rising clk edge.
REQ-026 Latency SHALL be 1 cycle: res_done, BResult, mispredict and illegal_op reflect the accepted branch in the cycle after acceptance.
REQ-027 Each output SHALL be 0 in any cycle following a non-accepted edge; outputs SHALL NOT hold over from earlier cycles.
REQ-028 On a legal acceptance, the indexed counter SHALL increment if taken and decrement if not taken, saturating at 11 and 00.
REQ-029 When pred_pc and res_pc map to the same index in the same cycle, pred_taken SHALL show the pre-update counter value; there is no bypass.
REQ-030 mispredict_cnt SHALL increment by 1 on each legal acceptance whose outcome differs from res_pred, saturating at all-ones.
REQ-031 flush=1 SHALL suppress all state updates and outputs for that cycle regardless of res_valid.
REQ-032 Back-to-back acceptances SHALL be supported every cycle; consecutive updates to one index SHALL accumulate.

Reset
REQ-033 rst=1 SHALL immediately, without waiting for clk, force every BHT counter to 01 (weakly not taken) and mispredict_cnt to 0.
REQ-034 rst=1 SHALL likewise force res_done, BResult, mispredict and illegal_op to 0.
REQ-035 A resolution in flight when rst asserts SHALL be discarded.
REQ-036 The first accepted edge after rst deasserts SHALL behave normally.

Verification
REQ-037 After reset, any pred_pc -> pred_taken=0. Accept BEQ with rd1=rd2=5 and res_pc=0x40, res_pred=0 -> next cycle res_done=1, BResult=1, mispredict=1, mispredict_cnt=1; pred_pc=0x40 then gives pred_taken=1.
REQ-038 Signed checks, WIDTH=32: BLTZ with rd1=0x80000000 -> BResult=1; BGTZ with rd1=0 -> 0; BLEZ with rd1=0 -> 1; BGEZ with rd1=0x7FFFFFFF -> 1; BNE with rd1=1, rd2=2 -> 1.
REQ-039 Saturation: 4 taken resolutions at one PC -> counter 11; a 5th taken -> stays 11; then 1 not-taken -> 10 and pred_taken still 1.
REQ-040 BTypeOp=111 with res_valid=1 -> illegal_op=1, BResult=0, BHT and mispredict_cnt unchanged; res_valid=1 with flush=1 -> res_done=0 and no state change.
REQ-041 Assert rst mid-cycle while res_valid=1 -> outputs drop to 0 before the next edge; counters return to 01; mispredict_cnt=0.
REQ-042 With CNT_W=2, 5 mispredicts -> mispredict_cnt holds 3.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch conditions one cycle after acceptance, trains a
// 2-bit-counter branch history table and counts mispredicts with saturation.
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [2:0]       BTypeOp,
    input  logic             res_pred,
    input  logic             flush,
    output logic             res_done,
    output logic             BResult,
    output logic             mispredict,
    output logic             illegal_op,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_done_q, res_done_d;
    logic             bresult_q, bresult_d;
    logic             mispredict_q, mispredict_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             taken;
    logic             illegal;
    logic             rd1_neg;
    logic             rd1_zero;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic [1:0]       bht_nxt;
    logic             bht_we;
    logic             unused_pc_bits;

    assign accept   = res_valid & ~flush;
    assign rd1_neg  = rd1[WIDTH-1];
    assign rd1_zero = (rd1 == '0);
    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];

    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], res_pc[31:IDX_W+2], res_pc[1:0]};

    // Zero comparisons only need the sign bit and an all-zero detect of rd1.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (BTypeOp)
            3'b000:  taken = (rd1 == rd2);
            3'b001:  taken = (rd1 != rd2);
            3'b010:  taken = rd1_neg | rd1_zero;
            3'b011:  taken = ~rd1_neg & ~rd1_zero;
            3'b100:  taken = rd1_neg;
            3'b101:  taken = ~rd1_neg;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        res_done_d   = accept;
        bresult_d    = accept & taken;
        mispredict_d = accept & (taken != res_pred);
        illegal_d    = accept & illegal;
        bht_we       = accept & ~illegal;
        bht_nxt      = bht_q[res_idx];
        if (taken && bht_q[res_idx] != 2'b11) begin
            bht_nxt = bht_q[res_idx] + 2'b01;
        end else if (!taken && bht_q[res_idx] != 2'b00) begin
            bht_nxt = bht_q[res_idx] - 2'b01;
        end
        cnt_d = cnt_q;
        if (bht_we && (taken != res_pred) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
            cnt_q        <= '0;
            res_done_q   <= 1'b0;
            bresult_q    <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            if (bht_we) begin
                bht_q[res_idx] <= bht_nxt;
            end
            cnt_q        <= cnt_d;
            res_done_q   <= res_done_d;
            bresult_q    <= bresult_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
        end
    end

    // Read of the pre-update counter: a same-cycle resolve to this index is not bypassed.
    assign pred_taken     = bht_q[pred_idx][1];
    assign res_done       = res_done_q;
    assign BResult        = bresult_q;
    assign mispredict     = mispredict_q;
    assign illegal_op     = illegal_q;
    assign mispredict_cnt = cnt_q;

endmodule
